// File: rtl/alu_ex_stage.sv
// Registered ALU output stage: captures result/carry, derives zero/neg/ovf flags,
// and hands them downstream through a two-entry skid buffer. Optional macro: ALU_STICKY_OVF_EN.
module alu_ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic [1:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf
`ifdef ALU_STICKY_OVF_EN
    ,
    output logic             sticky_ovf,
    input  logic             sticky_clr
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             cout;
        logic             zero;
        logic             neg;
        logic             ovf;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    localparam entry_t RST_ENTRY = '{res: '0, cout: 1'b0, zero: 1'b1, neg: 1'b0, ovf: 1'b0};

    state_e state_q, state_d;
    entry_t main_q, main_d, skid_q, skid_d, in_entry;
    logic   in_ready_q;
    logic   in_xfer, out_xfer;
    logic   load_main, load_skid, skid_to_main;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid & out_ready;

    // Flags are fixed at capture so the consumer sees them with zero added delay.
    always_comb begin
        in_entry.res  = alu_result;
        in_entry.cout = alu_cout;
        in_entry.zero = (alu_result == '0);
        in_entry.neg  = alu_result[WIDTH-1];
        in_entry.ovf  = (operation == 2'd2) & (a_msb == b_msb) & (alu_result[WIDTH-1] != a_msb);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (in_xfer) state_d = ONE;
            ONE: begin
                if (in_xfer && !out_xfer)      state_d = TWO;
                else if (!in_xfer && out_xfer) state_d = EMPTY;
            end
            TWO:     if (out_xfer) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_valid    = (state_q != EMPTY);
        load_main    = in_xfer & ((state_q == EMPTY) | ((state_q == ONE) & out_xfer));
        load_skid    = in_xfer & (state_q == ONE) & ~out_xfer;
        skid_to_main = (state_q == TWO) & out_xfer;
    end

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (load_main)         main_d = in_entry;
        else if (skid_to_main) main_d = skid_q;
        if (load_skid)         skid_d = in_entry;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q <= RST_ENTRY;
            skid_q <= RST_ENTRY;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_result = main_q.res;
    assign out_cout   = main_q.cout;
    assign out_zero   = main_q.zero;
    assign out_neg    = main_q.neg;
    assign out_ovf    = main_q.ovf;

`ifdef ALU_STICKY_OVF_EN
    logic sticky_q;

    // Clear wins over a same-edge set.
    always_ff @(posedge clk_i) begin
        if (rst_i)                      sticky_q <= 1'b0;
        else if (sticky_clr)            sticky_q <= 1'b0;
        else if (out_xfer && main_q.ovf) sticky_q <= 1'b1;
    end

    assign sticky_ovf = sticky_q;
`endif

endmodule

// File: tb/tb_alu_ex_stage.sv
// Self-checking bench for alu_ex_stage: table vectors plus hand sequences, scoreboard-checked outputs.
module tb_alu_ex_stage;

    localparam int W = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          in_valid, in_ready;
    logic [W-1:0]  alu_result;
    logic          alu_cout, a_msb, b_msb;
    logic [1:0]    operation;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_result;
    logic          out_cout, out_zero, out_neg, out_ovf;
`ifdef ALU_STICKY_OVF_EN
    logic          sticky_ovf, sticky_clr;
`endif

    always #5 clk_i = ~clk_i;

    alu_ex_stage #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .a_msb(a_msb), .b_msb(b_msb), .operation(operation),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_cout(out_cout),
        .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf)
`ifdef ALU_STICKY_OVF_EN
        , .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr)
`endif
    );

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         zero;
        logic         neg;
        logic         ovf;
    } exp_t;

    typedef struct {
        logic [W-1:0] res;
        logic [1:0]   op;
        logic         am;
        logic         bm;
        logic         cout;
        logic         ez;
        logic         en;
        logic         eo;
    } vec_t;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t cur_exp;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard: pop on output transfer, push on input transfer; reset flushes.
    always @(negedge clk_i) begin
        if (rst_i) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got res=%h with no entry outstanding", out_result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (out_result !== e.res || out_cout !== e.cout || out_zero !== e.zero ||
                        out_neg !== e.neg || out_ovf !== e.ovf) begin
                        n_fail++;
                        $display("FAIL sb_entry: got res=%h c=%b z=%b n=%b o=%b expected res=%h c=%b z=%b n=%b o=%b",
                                 out_result, out_cout, out_zero, out_neg, out_ovf,
                                 e.res, e.cout, e.zero, e.neg, e.ovf);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    task automatic drive(input vec_t v);
        in_valid   = 1'b1;
        alu_result = v.res;
        operation  = v.op;
        a_msb      = v.am;
        b_msb      = v.bm;
        alu_cout   = v.cout;
        cur_exp    = '{res: v.res, cout: v.cout, zero: v.ez, neg: v.en, ovf: v.eo};
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic vec_t plain(input logic [W-1:0] r);
        vec_t v;
        v = '{res: r, op: 2'd0, am: 1'b0, bm: 1'b0, cout: 1'b0,
              ez: (r == '0), en: r[W-1], eo: 1'b0};
        return v;
    endfunction

    vec_t tbl[10];

    initial begin
        tbl[0] = '{32'h0000_0000, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{32'h8000_0000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{32'h8000_0000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{32'h7FFF_FFFF, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{32'h7FFF_FFFF, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{32'hFFFF_FFFF, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{32'h0000_0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{32'h8000_0000, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{32'h0000_1234, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{32'h0000_0000, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        rst_i = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_result = '0; alu_cout = 1'b0; a_msb = 1'b0; b_msb = 1'b0; operation = 2'd0;
        cur_exp = '{res: '0, cout: 1'b0, zero: 1'b1, neg: 1'b0, ovf: 1'b0};
`ifdef ALU_STICKY_OVF_EN
        sticky_clr = 1'b0;
`endif
        tick(); tick();
        rst_i = 1'b0;

        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready, 1);
        chk("rst_result",    out_result, 0);
        chk("rst_cout",      out_cout, 0);
        chk("rst_zero",      out_zero, 1);
        chk("rst_neg",       out_neg, 0);
        chk("rst_ovf",       out_ovf, 0);
`ifdef ALU_STICKY_OVF_EN
        chk("rst_sticky",    sticky_ovf, 0);
`endif

        // one-cycle latency from EMPTY
        out_ready = 1'b1;
        drive(tbl[0]);
        tick();
        in_valid = 1'b0;
        chk("lat_out_valid", out_valid, 1);
        chk("lat_in_ready",  in_ready, 1);
        chk("lat_zero",      out_zero, 1);
        tick();
        chk("lat_drained",   out_valid, 0);

        // table vectors, back to back
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i]);
            tick();
            chk("tbl_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();

        // streaming 1..8
        for (int i = 1; i <= 8; i++) begin
            drive(plain(W'(i)));
            tick();
            chk("strm_in_ready", in_ready, 1);
            chk("strm_result",   out_result, W'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("strm_drained", out_valid, 0);

        // back-pressure fills both entries
        out_ready = 1'b0;
        drive(plain(32'd1)); tick();
        chk("bp_in_ready_one", in_ready, 1);
        drive(plain(32'd2)); tick();
        in_valid = 1'b0;
        chk("bp_in_ready_two", in_ready, 0);
        chk("bp_out_valid",    out_valid, 1);
        tick(); tick();
        chk("bp_hold_result",  out_result, 32'd1);
        chk("bp_hold_ready",   in_ready, 0);
        out_ready = 1'b1;
        tick();
        chk("bp_second",       out_result, 32'd2);
        chk("bp_ready_back",   in_ready, 1);
        tick();
        chk("bp_drained",      out_valid, 0);

        // reset while TWO entries are held; neither may ever emerge
        out_ready = 1'b0;
        drive(plain(32'd5)); tick();
        drive(plain(32'd6)); tick();
        in_valid = 1'b0;
        chk("mr_two", in_ready, 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_in_ready",  in_ready, 1);
        chk("mr_zero",      out_zero, 1);
        chk("mr_result",    out_result, 0);
        out_ready = 1'b1;
        tick(); tick();
        chk("mr_stay_empty", out_valid, 0);
        drive(plain(32'd7)); tick();
        in_valid = 1'b0;
        chk("mr_after", out_result, 32'd7);
        tick();

`ifdef ALU_STICKY_OVF_EN
        drive(tbl[1]); tick();
        drive(plain(32'd9)); tick();
        drive(plain(32'd10)); tick();
        in_valid = 1'b0;
        tick();
        chk("sticky_set", sticky_ovf, 1);
        drive(tbl[3]); tick();
        in_valid = 1'b0;
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        chk("sticky_clr_wins", sticky_ovf, 0);
        tick();
        chk("sticky_stays_clr", sticky_ovf, 0);
`endif

        // bounded drain of anything still outstanding
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("sb_empty", W'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
- Registered output stage directly downstream of the 32-bit ALU built from alu slices.
- Captures ALU result, carry-out and compare context; derives zero/overflow/negative flags.
- Presents them to the consumer (writeback/branch logic) over a valid/ready handshake.
- Two-entry skid buffer so in_ready is a pure register output and downstream back-pressure never creates a combinational path into the ALU.

Parameters:
- WIDTH, 32, datapath width of alu_result and out_result (min 2)

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  synchronous, active-high reset
- in_valid  input  1  ALU output valid this cycle
- in_ready  output  1  stage can accept; registered
- alu_result  input  WIDTH  ALU result bus
- alu_cout  input  1  carry-out of MSB slice
- a_msb  input  1  src1[WIDTH-1] after A_invert applied
- b_msb  input  1  src2[WIDTH-1] after B_invert applied
- operation  input  2  ALU operation (0 AND, 1 OR, 2 ADD/SUB, 3 compare)
- out_valid  output  1  entry presented
- out_ready  input  1  consumer accepts
- out_result  output  WIDTH  registered result
- out_cout  output  1  registered carry-out
- out_zero  output  1  out_result == 0
- out_neg  output  1  out_result[WIDTH-1]
- out_ovf  output  1  signed overflow (ADD/SUB only)

Behaviour:
- Reset (rst_i=1 at edge): state EMPTY; out_valid=0, in_ready=1; out_result=0, out_cout=0, out_zero=1, out_neg=0, out_ovf=0; sticky_ovf=0 if enabled. Reset mid-transfer drops all entries; no entry survives.
- Input transfer: in_valid & in_ready at an edge. Output transfer: out_valid & out_ready at an edge.
- Flags are computed at capture and stored with the entry:
  - zero = (alu_result == 0)
  - neg = alu_result[WIDTH-1]
  - ovf = (operation==2) & (a_msb == b_msb) & (alu_result[WIDTH-1] != a_msb); ovf=0 for ops 0, 1, 3.
- Latency: 1 cycle from input transfer into EMPTY to out_valid=1 with that entry.
- Entries: main (drives out_*) and skid. States:
  - EMPTY: in xfer -> ONE (load main).
  - ONE: in xfer & out xfer -> ONE (main reloaded); in xfer only -> TWO (load skid); out xfer only -> EMPTY; neither -> ONE.
  - TWO: in_ready=0; out xfer -> ONE (skid moves to main); else hold.
- in_ready = (state != TWO), registered. out_valid = (state != EMPTY).
- out_* hold stable while out_valid=1 and out_ready=0.
- Order strictly FIFO; no entry is dropped or duplicated.
- When EMPTY, out_result/flags keep their last values (don't care to consumer); out_valid=0.
- in_valid without in_ready: input ignored, upstream must hold.

Optional Feature:
- Macro ALU_STICKY_OVF_EN.
- Defined:
  - Adds port sticky_ovf output 1 and port sticky_clr input 1.
  - sticky_ovf sets on any output transfer whose out_ovf=1.
  - sticky_clr=1 clears it at the edge; clear has priority over a same-cycle set.
  - Reset value 0.
- Not defined: both ports and the register are absent; all other behaviour unchanged.

Test Plan:
- Reset, then in_valid=1, alu_result=32'h0000_0000, operation=2, out_ready=1 -> next cycle out_valid=1, out_zero=1, out_neg=0, out_ovf=0; in_ready stays 1.
- ADD overflow: a_msb=0, b_msb=0, alu_result=32'h8000_0000, operation=2 -> out_ovf=1, out_neg=1; same values with operation=1 -> out_ovf=0.
- Back-pressure: out_ready=0, send results 1, 2 on consecutive cycles -> in_ready=0 after second; release out_ready -> outputs 1 then 2 on consecutive cycles; in_ready returns to 1 one cycle after first out transfer.
- Streaming: in_valid=1 and out_ready=1 continuously, results 1..8 -> out_result 1..8 one per cycle, in_ready never 0.
- Reset mid-operation: state TWO holding 5, 6; assert rst_i one cycle -> out_valid=0, in_ready=1, out_zero=1; neither 5 nor 6 ever appears at the output.
- ALU_STICKY_OVF_EN: transfer one ovf entry, then clean entries -> sticky_ovf=1 held; sticky_clr=1 in the same cycle as another ovf transfer -> sticky_ovf=0 next cycle.
